pm_column: RTL



---
 rtl/pmc_pkg.sv | 16 +
 rtl/pm_pixel.sv | 53 +++++
 rtl/pm_column.sv | 78 +++++++
 3 files changed

// File: rtl/pmc_pkg.sv
// Shared sizing and control-decode types for the pixel-matrix column model.
// Geometry defaults here are also used by the matrix controller for din/dout sizing.
package pmc_pkg;

    localparam int PM_ROWS      = 16;
    localparam int PM_CNT_WIDTH = 16;

    // Decoded per-cycle actions broadcast from the column to every pixel.
    typedef struct packed {
        logic shift_a;
        logic shift_b;
        logic load;
        logic count;
    } pm_ctrl_t;

endpackage

// File: rtl/pm_pixel.sv
// One pixel: hit counter plus its slices of readout chain A and config chain B.
// Counter overflow wraps unless PM_COLUMN_CNT_SATURATE_EN is defined (then it saturates).
module pm_pixel
    import pmc_pkg::*;
#(
    parameter int CNT_WIDTH = PM_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  pm_ctrl_t             ctrl,
    input  logic                 in_a,
    input  logic                 in_b,
    output logic                 out_a,
    output logic                 out_b,
    output logic [CNT_WIDTH-1:0] cfg_slice
);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] a_q;
    logic [CNT_WIDTH-1:0] b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            // Load and shift_a are exclusive by decode; a hit coincident with a load opens the new period.
            if (ctrl.load) begin
                a_q <= cnt;
                cnt <= ctrl.count ? CNT_WIDTH'(1) : '0;
            end else begin
                if (ctrl.shift_a)
                    a_q <= {a_q[CNT_WIDTH-2:0], in_a};
                if (ctrl.count) begin
`ifdef PM_COLUMN_CNT_SATURATE_EN
                    if (!(&cnt))
                        cnt <= cnt + 1'b1;
`else
                    cnt <= cnt + 1'b1;
`endif
                end
            end
            if (ctrl.shift_b)
                b_q <= {b_q[CNT_WIDTH-2:0], in_b};
        end
    end

    assign out_a     = a_q[CNT_WIDTH-1];
    assign out_b     = b_q[CNT_WIDTH-1];
    assign cfg_slice = b_q;

endmodule

// File: rtl/pm_column.sv
// Pixel-matrix column stand-in: edge-detects the controller lines and drives ROWS pixels.
// Build option PM_COLUMN_CNT_SATURATE_EN selects saturating rather than wrapping counters.
module pm_column
    import pmc_pkg::*;
#(
    parameter int ROWS      = PM_ROWS,
    parameter int CNT_WIDTH = PM_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din,
    input  logic                      clk_sh,
    input  logic                      sh_a,
    input  logic                      sh_b,
    input  logic                      store,
    input  logic                      strobe,
    input  logic                      gate,
    output logic                      dout_a,
    output logic                      dout_b,
    output logic [ROWS*CNT_WIDTH-1:0] cfg
);

    logic clk_sh_prev;
    logic store_prev;
    logic strobe_prev;
    logic clk_sh_rise;
    logic store_rise;
    logic strobe_rise;
    pm_ctrl_t ctrl;

    // Previous values reset high so a level already asserted at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sh_prev <= 1'b1;
            store_prev  <= 1'b1;
            strobe_prev <= 1'b1;
        end else begin
            clk_sh_prev <= clk_sh;
            store_prev  <= store;
            strobe_prev <= strobe;
        end
    end

    assign clk_sh_rise = clk_sh & ~clk_sh_prev;
    assign store_rise  = store  & ~store_prev;
    assign strobe_rise = strobe & ~strobe_prev;

    // Shifting chain A wins: a store while sh_a is high neither loads nor clears.
    assign ctrl.shift_a = clk_sh_rise & sh_a;
    assign ctrl.shift_b = clk_sh_rise & sh_b;
    assign ctrl.load    = store_rise & ~sh_a;
    assign ctrl.count   = strobe_rise & gate;

    logic [ROWS:0] link_a;
    logic [ROWS:0] link_b;

    assign link_a[0] = din;
    assign link_b[0] = din;

    for (genvar r = 0; r < ROWS; r++) begin : g_pixel
        pm_pixel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_pixel (
            .clk       (clk),
            .rst       (rst),
            .ctrl      (ctrl),
            .in_a      (link_a[r]),
            .in_b      (link_b[r]),
            .out_a     (link_a[r+1]),
            .out_b     (link_b[r+1]),
            .cfg_slice (cfg[r*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    assign dout_a = link_a[ROWS];
    assign dout_b = link_b[ROWS];

endmodule
